// File: rtl/csr_timer_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_bank_if
// Description : CSR read/write bus shared by the core CSR file and the
//               timer bank. The master presents the address and write
//               strobe; the slave returns combinational read data and hit.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_timer_bank_if;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        csr_hit;

  modport master (
    output csr_num, csr_we, csr_wmask, csr_wvalue,
    input  csr_rvalue, csr_hit
  );

  modport slave (
    input  csr_num, csr_we, csr_wmask, csr_wvalue,
    output csr_rvalue, csr_hit
  );
endinterface
`default_nettype wire

// File: rtl/csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_bank
// Description : NCH independent countdown timers with per-channel
//               TCFG/TVAL/TICLR CSRs, a global IEN CSR and a prioritised
//               interrupt output (lowest enabled pending channel wins).
//               Optional macro TIMER_PRESCALE_EN adds a free-running
//               prescaler (parameter PRESCALE) gating the count ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer_bank #(
  parameter int          NCH      = 4,
  parameter int          CNT_W    = 32,
  parameter logic [13:0] CSR_BASE = 14'h41
`ifdef TIMER_PRESCALE_EN
  , parameter int        PRESCALE = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  csr_timer_bank_if.slave  csr,
  input  logic             count_stop,
  output logic [NCH-1:0]   timer_pend,
  output logic             irq_any,
  output logic [2:0]       irq_id
);

  localparam logic [CNT_W-1:0] c_cnt_ones = '1;

  // Address decode: offset from the base, 4 CSRs per channel, IEN last.
  logic [13:0] w_off;
  logic        w_in_map;
  logic        w_is_ien;
  logic [3:0]  w_ch;
  logic [1:0]  w_sub;

  assign w_off    = csr.csr_num - CSR_BASE;
  assign w_in_map = (csr.csr_num >= CSR_BASE) && (w_off <= 14'(4 * NCH));
  assign w_is_ien = w_in_map && (w_off == 14'(4 * NCH));
  assign w_ch     = w_off[5:2];
  assign w_sub    = w_off[1:0];

  logic [CNT_W-1:0] r_cfg [NCH];   // {initval, periodic, en}
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   r_ien;

  logic [NCH-1:0]   w_sel;
  logic [NCH-1:0]   w_cfg_we;
  logic [NCH-1:0]   w_clr;
  logic [NCH-1:0]   w_set;
  logic [CNT_W-1:0] w_cfg_new [NCH];
  logic [NCH-1:0]   w_ien_new;
  logic             w_tick;

`ifdef TIMER_PRESCALE_EN
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PRE_W-1:0] r_pre;

  // Free-running prescaler, frozen together with the counters by count_stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (!count_stop) begin
      r_pre <= (r_pre == PRE_W'(PRESCALE - 1)) ? '0 : r_pre + PRE_W'(1);
    end
  end

  assign w_tick = !count_stop && (r_pre == PRE_W'(PRESCALE - 1));
`else
  assign w_tick = !count_stop;
`endif

  // Per-channel write strobes, merged TCFG value and pend set/clear terms.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_sel[c]     = w_in_map && !w_is_ien && (w_ch == 4'(c));
      w_cfg_we[c]  = csr.csr_we && w_sel[c] && (w_sub == 2'd0);
      w_clr[c]     = csr.csr_we && w_sel[c] && (w_sub == 2'd3) &&
                     csr.csr_wmask[0] && csr.csr_wvalue[0];
      w_cfg_new[c] = (csr.csr_wmask[CNT_W-1:0] & csr.csr_wvalue[CNT_W-1:0]) |
                     (~csr.csr_wmask[CNT_W-1:0] & r_cfg[c]);
      // A TCFG write preempts counting, so it also blocks the pend event.
      w_set[c]     = w_tick && r_cfg[c][0] && !w_cfg_we[c] && (r_cnt[c] == '0);
    end
  end

  assign w_ien_new = (csr.csr_wmask[NCH-1:0] & csr.csr_wvalue[NCH-1:0]) |
                     (~csr.csr_wmask[NCH-1:0] & r_ien);

  // Configuration, counters, pend flags and interrupt enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        r_cfg[c] <= '0;
        r_cnt[c] <= c_cnt_ones;
      end
      r_pend <= '0;
      r_ien  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_cfg_we[c]) begin
          r_cfg[c] <= w_cfg_new[c];
          if (w_cfg_new[c][0]) begin
            r_cnt[c] <= {w_cfg_new[c][CNT_W-1:2], 2'b00};
          end
        end else if (w_tick && r_cfg[c][0] && (r_cnt[c] != c_cnt_ones)) begin
          if (r_cnt[c] == '0) begin
            // Periodic reloads; one-shot wraps to all-ones and parks there.
            r_cnt[c] <= r_cfg[c][1] ? {r_cfg[c][CNT_W-1:2], 2'b00} : c_cnt_ones;
          end else begin
            r_cnt[c] <= r_cnt[c] - CNT_W'(1);
          end
        end
        // Set beats clear when both land on the same edge.
        r_pend[c] <= w_set[c] | (r_pend[c] & ~w_clr[c]);
      end
      if (csr.csr_we && w_is_ien) begin
        r_ien <= w_ien_new;
      end
    end
  end

  // Combinational read mux; TICLR, offset +2 and unmapped addresses read 0.
  always_comb begin
    csr.csr_rvalue = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_sel[c]) begin
        case (w_sub)
          2'd0:    csr.csr_rvalue = 32'(r_cfg[c]);
          2'd1:    csr.csr_rvalue = 32'(r_cnt[c]);
          default: csr.csr_rvalue = '0;
        endcase
      end
    end
    if (w_is_ien) begin
      csr.csr_rvalue = 32'(r_ien);
    end
  end

  assign csr.csr_hit = w_in_map;

  // Lowest-numbered enabled pending channel; scanned high to low so low wins.
  always_comb begin
    irq_id = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (r_pend[c] && r_ien[c]) begin
        irq_id = 3'(c);
      end
    end
  end

  assign irq_any    = |(r_pend & r_ien);
  assign timer_pend = r_pend;

endmodule
`default_nettype wire

// File: doc/csr_timer_bank.md
Name: csr_timer_bank

Overview:
- Parametrised successor to the single-timer CSR logic.
- Provides NCH independent countdown timers, each with its own TCFG/TVAL/TICLR CSR triple, a global interrupt-enable CSR, and a prioritised interrupt output.
- Sits beside the core CSR file on the same CSR read/write bus. The core CSR file ORs `csr_hit`-qualified `csr_rvalue` into its own read mux and routes `irq_any` into ESTAT.IS[11].

Parameters:
- NCH, 4, number of timer channels (1..8).
- CNT_W, 32, counter and TVAL width in bits (8..32). The initval field is CNT_W-2 bits.
- CSR_BASE, 14'h41, CSR number of channel 0 TCFG.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- csr_num  in  14  CSR address for the read and write currently presented
- csr_we  in  1  write strobe, qualified by address match
- csr_wmask  in  32  per-bit write mask
- csr_wvalue  in  32  write data
- csr_rvalue  out  32  combinational read data; 0 when no match
- csr_hit  out  1  combinational; csr_num falls inside this block's map
- count_stop  in  1  freezes all decrements (debug halt)
- timer_pend  out  NCH  per-channel pending flags
- irq_any  out  1  OR over (timer_pend & ien)
- irq_id  out  3  index of the lowest-numbered enabled pending channel; 0 if none

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Register map for channel c:
  - TCFG = CSR_BASE+4c, fields: en[0], periodic[1], initval[CNT_W-1:2].
  - TVAL = CSR_BASE+4c+1, read-only, zero-extended counter.
  - TICLR = CSR_BASE+4c+3, write-1-to-clear bit0, reads 0.
  - IEN = CSR_BASE+4*NCH, bits[NCH-1:0] read/write.
  - Offset +2, and IEN bits at or above NCH, read 0 and are not writable.
  - Unmapped bits in every register read 0.
- Write rule: new = (wmask & wvalue) | (~wmask & old), applied on the clock edge when csr_we is high and the address matches.
- Reset values: en=0, periodic=0, initval=0, counter=all-ones, pend=0, ien=0. All outputs are derived from these values, so irq_any=0 and irq_id=0 at reset.
- TCFG write with resulting en=1: counter loads {new initval, 2'b00} on the next edge. This takes priority over that channel's decrement in the same cycle. A restart while the channel is already running also reloads.
- TCFG write with resulting en=0: counting stops and the counter holds its value.
- Counting, applied each cycle when en=1, count_stop=0, and no TCFG load:
  - counter == all-ones: hold. The one-shot channel has expired.
  - counter == 0 and periodic=1: reload {initval,2'b00} and set pend.
  - counter == 0 and periodic=0: decrement wraps to all-ones and stops; set pend.
  - Otherwise: counter -= 1.
- Pend is set on the edge where the counter leaves 0 under the conditions above.
- If count_stop=1 while the counter is 0: no pend and no change. The event fires once count_stop deasserts.
- A TICLR write with (wmask[0] & wvalue[0])=1 clears pend. If a set and a clear happen on the same edge, the set wins.
- Initval=0 with periodic=1 fires every cycle (period 1 after the load) and is legal.
- irq_id and irq_any are purely combinational from the pend and ien registers, so they change 1 cycle after the causing event.
- Reset mid-count: all state returns to reset values on that edge; no pend survives.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- When defined, adds parameter PRESCALE (default 16) and a free-running prescaler counter that is reset to 0 and wraps at PRESCALE-1.
  - Decrement, reload, and pend-set occur only on cycles where the prescaler equals PRESCALE-1 and count_stop=0.
  - count_stop also freezes the prescaler.
  - TCFG loads remain immediate.
- When undefined, ticks occur every cycle and there is no prescaler state.

Test Plan:
- Reset, then read all TCFG/TVAL/IEN -> TCFG=0, TVAL=0xFFFFFFFF, IEN=0; irq_any=0.
- ch0 TCFG=0x0000_0015 (initval=5, periodic=0, en=1) with IEN=0x1 -> TVAL counts 0x14 down to 0. pend0 rises 21 cycles after the load edge; TVAL=0xFFFFFFFF and holds; irq_any=1, irq_id=0.
- ch2 TCFG=0x0B (initval=2, periodic, en) -> pend2 sets every 9 cycles. TICLR2=1 clears it; when a TICLR write coincides with the counter at 0, pend2 stays 1.
- ch1 and ch3 both pending with IEN=0xA -> irq_id=1. After TICLR1: irq_id=3. After IEN=0x0: irq_any=0 and timer_pend still reads 4'b1010.
- ch0 running; assert count_stop for 10 cycles -> TVAL frozen. A TCFG write with wmask=0x1 and wvalue=0 -> en=0, initval unchanged, TVAL holds.
- Assert reset while ch0 is at TVAL=3 -> next cycle TVAL=0xFFFFFFFF, pend=0, en=0.
